// File: rtl/scene_sequencer.sv
// scene_sequencer: per-frame show sequencer producing anim_ctr, scene, layer enables and fade level.
// Optional SEQ_REVERSE_EN adds a dir input that makes anim_ctr count down.
module scene_sequencer #(
    parameter int FADE_STEP     = 8,
    parameter int SCROLL_FRAMES = 240,
    parameter int HOLD_FRAMES   = 60,
    parameter int NUM_SCENES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       pause,
    input  logic       skip,
`ifdef SEQ_REVERSE_EN
    input  logic       dir,
`endif
    output logic [9:0] anim_ctr,
    output logic [1:0] scene,
    output logic [2:0] layer_en,
    output logic [1:0] fade,
    output logic [1:0] state,
    output logic       frame_tick
);
    typedef enum logic [1:0] {FADE_IN, SCROLL, HOLD, FADE_OUT} state_t;
    localparam logic [9:0] FADE_END   = 10'(FADE_STEP - 1);
    localparam logic [9:0] SCROLL_END = 10'(SCROLL_FRAMES - 1);
    localparam logic [9:0] HOLD_END   = 10'(HOLD_FRAMES - 1);
    localparam logic [1:0] LAST_SCENE = 2'(NUM_SCENES - 1);

    state_t     cur, nxt;
    logic       v_sync_q, skip_pend, skip_nxt, skip_eff, run, rev;
    logic [9:0] dwell, dwell_nxt, anim_nxt;
    logic [1:0] fade_nxt, scene_nxt;

`ifdef SEQ_REVERSE_EN
    assign rev = dir;
`else
    assign rev = 1'b0;
`endif
    assign run      = frame_tick & ~pause;
    // a skip arriving on the tick cycle itself still applies to that tick
    assign skip_eff = skip_pend | skip;
    assign state    = cur;
    assign layer_en = scene == 2'd0 ? 3'b001 :
                      scene == 2'd1 ? 3'b011 :
                      scene == 2'd2 ? 3'b111 : 3'b100;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q   <= 1'b0;
            frame_tick <= 1'b0;
            anim_ctr   <= '0;
            scene      <= '0;
            fade       <= '0;
            cur        <= FADE_IN;
            dwell      <= '0;
            skip_pend  <= 1'b0;
        end else begin
            v_sync_q   <= v_sync;
            frame_tick <= v_sync & ~v_sync_q;
            anim_ctr   <= anim_nxt;
            scene      <= scene_nxt;
            fade       <= fade_nxt;
            cur        <= nxt;
            dwell      <= dwell_nxt;
            skip_pend  <= skip_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        dwell_nxt = dwell;
        fade_nxt  = fade;
        scene_nxt = scene;
        anim_nxt  = anim_ctr;
        skip_nxt  = run ? 1'b0 : skip_eff;
        if (run) begin
            if (cur != HOLD) anim_nxt = rev ? anim_ctr - 10'd1 : anim_ctr + 10'd1;
            dwell_nxt = dwell + 10'd1;
            case (cur)
                FADE_IN: if (dwell == FADE_END) begin
                    dwell_nxt = '0;
                    fade_nxt  = fade + 2'd1;
                    if (fade == 2'd2) nxt = SCROLL;
                end
                SCROLL: if (skip_eff || dwell == SCROLL_END) begin
                    dwell_nxt = '0;
                    nxt       = skip_eff ? FADE_OUT : HOLD;
                end
                HOLD: if (skip_eff || dwell == HOLD_END) begin
                    dwell_nxt = '0;
                    nxt       = FADE_OUT;
                end
                FADE_OUT: if (dwell == FADE_END) begin
                    dwell_nxt = '0;
                    fade_nxt  = fade - 2'd1;
                    if (fade == 2'd1) begin
                        scene_nxt = scene == LAST_SCENE ? 2'd0 : scene + 2'd1;
                        nxt       = FADE_IN;
                    end
                end
            endcase
        end
    end
endmodule
